pipe_stage_reg: RTL and testbench

- Parametrised successor to the fixed-field inter-stage registers (EX/MEM style) in the 5-stage pipeline.
- Carries a packed control vector and a packed data vector from one stage to the next.
- Adds a valid/ready handshake, an optional 2-entry skid buffer, flush/bubble insertion and a saturating stall-cycle counter for performance debug.
- Every pipeline boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) instantiates it with its own widths.

---
 rtl/pipe_stage_reg.sv | 123 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional two-entry skid buffer,
// flush/bubble insertion and a saturating stall-cycle counter.
module pipe_stage_reg #(
  parameter int CTRL_W      = 4,
  parameter int DATA_W      = 101,
  parameter int SKID        = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_data,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  input  logic                   stall_cnt_clr
);

  logic                   r_live;
  logic                   r_head_v;
  logic [CTRL_W-1:0]      r_head_ctrl;
  logic [DATA_W-1:0]      r_head_data;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   w_skid_v;
  logic                   w_in_xfer;
  logic                   w_out_xfer;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = r_head_v & out_ready;

  // Holds in_ready low while in reset and releases it on the first edge afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_live <= 1'b0;
    else     r_live <= 1'b1;
  end

  generate
    if (SKID != 0) begin : gen_skid
      logic              r_skid_v;
      logic [CTRL_W-1:0] r_skid_ctrl;
      logic [DATA_W-1:0] r_skid_data;
      logic              w_head_load;

      assign w_head_load = !r_head_v || w_out_xfer;
      // in_ready is a pure register output, so out_ready never reaches it combinationally.
      assign in_ready    = r_live & !r_skid_v;
      assign w_skid_v    = r_skid_v;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_head_v <= 1'b0;
          r_skid_v <= 1'b0;
        end else if (flush) begin
          r_head_v <= 1'b0;
          r_skid_v <= 1'b0;
        end else if (w_head_load) begin
          if (r_skid_v) begin
            r_head_v <= 1'b1;
            r_skid_v <= 1'b0;
          end else begin
            r_head_v <= w_in_xfer;
          end
        end else if (w_in_xfer) begin
          r_skid_v <= 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (w_head_load) begin
          if (r_skid_v) begin
            r_head_ctrl <= r_skid_ctrl;
            r_head_data <= r_skid_data;
          end else if (w_in_xfer) begin
            r_head_ctrl <= in_ctrl;
            r_head_data <= in_data;
          end
        end
        if (w_in_xfer && !w_head_load) begin
          r_skid_ctrl <= in_ctrl;
          r_skid_data <= in_data;
        end
      end
    end else begin : gen_single
      assign in_ready = r_live & (!r_head_v | out_ready);
      assign w_skid_v = 1'b0;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_head_v <= 1'b0;
        else if (flush)      r_head_v <= 1'b0;
        else if (w_in_xfer)  r_head_v <= 1'b1;
        else if (w_out_xfer) r_head_v <= 1'b0;
      end

      always_ff @(posedge clk) begin
        if (w_in_xfer) begin
          r_head_ctrl <= in_ctrl;
          r_head_data <= in_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    r_stall_cnt <= '0;
    else if (stall_cnt_clr)                     r_stall_cnt <= '0;
    else if (r_head_v && !out_ready && !(&r_stall_cnt))
                                                r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
  end

  assign out_valid = r_head_v;
  // Bubbles carry no control bits, so a consumer without a valid check sees no writes.
  assign out_ctrl  = r_head_v ? r_head_ctrl : '0;
  assign out_data  = r_head_data;
  assign occupancy = {1'b0, r_head_v} + {1'b0, w_skid_v};
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed scoreboard bench for pipe_stage_reg: skid variant, single-entry variant and a
// 4-bit stall counter variant.
module tb_pipe_stage_reg;
  localparam int CW = 4;
  localparam int DW = 101;

  logic          clk, rst;
  logic          in_valid, out_ready, in_valid0, out_ready0, flush, stall_cnt_clr;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt;

  logic          in_ready0, out_valid0;
  logic [CW-1:0] out_ctrl0;
  logic [DW-1:0] out_data0;
  logic [1:0]    occupancy0;
  logic [15:0]   stall_cnt0;

  logic          in_ready4, out_valid4;
  logic [CW-1:0] out_ctrl4;
  logic [DW-1:0] out_data4;
  logic [1:0]    occupancy4;
  logic [3:0]    stall_cnt4;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .STALL_CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy), .stall_cnt(stall_cnt),
    .stall_cnt_clr(stall_cnt_clr));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .STALL_CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl),
    .in_data(in_data), .flush(flush), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_ctrl(out_ctrl0), .out_data(out_data0), .occupancy(occupancy0), .stall_cnt(stall_cnt0),
    .stall_cnt_clr(stall_cnt_clr));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .STALL_CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_ctrl(in_ctrl),
    .in_data(in_data), .flush(flush), .out_valid(out_valid4), .out_ready(out_ready),
    .out_ctrl(out_ctrl4), .out_data(out_data4), .occupancy(occupancy4), .stall_cnt(stall_cnt4),
    .stall_cnt_clr(stall_cnt_clr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [104:0] q[$];
  logic [31:0]  seq;
  logic [15:0]  exp_st;
  logic [3:0]   exp_st4;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs for the coming edge, check current outputs, then model that edge.
  task automatic step(input bit sel0, input bit iv, input bit ord, input bit fl, input bit clr,
                      input bit exp_rdy, input bit exp_ov, input logic [1:0] exp_occ);
    logic [104:0] h;
    @(posedge clk);
    #1;
    flush         = fl;
    stall_cnt_clr = clr;
    in_data       = {seq, ~seq, seq, seq[4:0]};
    in_ctrl       = fl ? 4'hF : {seq[2:0], 1'b1};
    if (sel0) begin
      in_valid0 = iv; out_ready0 = ord; in_valid = 1'b0; out_ready = 1'b1;
    end else begin
      in_valid = iv; out_ready = ord; in_valid0 = 1'b0; out_ready0 = 1'b1;
    end
    #1;
    chk("in_ready",  sel0 ? in_ready0  : in_ready,  exp_rdy);
    chk("out_valid", sel0 ? out_valid0 : out_valid, exp_ov);
    chk("occupancy", sel0 ? occupancy0 : occupancy, exp_occ);
    if (exp_ov) begin
      if (q.size() == 0) begin
        n_tests++; n_fail++;
        $error("FAIL scoreboard: observed empty queue expected an entry");
      end else begin
        h = q[0];
        chk("out_ctrl", sel0 ? out_ctrl0 : out_ctrl, h[104:101]);
        chk("out_data", sel0 ? out_data0 : out_data, h[100:0]);
      end
    end else begin
      chk("bubble_ctrl", sel0 ? out_ctrl0 : out_ctrl, 0);
    end
    if (!sel0) begin
      chk("stall_cnt",  stall_cnt,  exp_st);
      chk("stall_cnt4", stall_cnt4, exp_st4);
    end
    if (exp_ov && ord && q.size() > 0) void'(q.pop_front());
    if (iv && exp_rdy) begin
      q.push_back({in_ctrl, in_data});
      seq++;
    end
    if (fl) q.delete();
    if (!sel0) begin
      if (clr) begin
        exp_st = '0; exp_st4 = '0;
      end else if (exp_ov && !ord) begin
        if (exp_st  != '1) exp_st++;
        if (exp_st4 != '1) exp_st4++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_valid0 = 1'b0; out_ready0 = 1'b1;
    flush = 1'b0; stall_cnt_clr = 1'b0; in_ctrl = '0; in_data = '0;
    seq = 32'd1; exp_st = '0; exp_st4 = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  in_ready,   0);
    chk("rst_in_ready0", in_ready0,  0);
    chk("rst_out_valid", out_valid,  0);
    chk("rst_out_ctrl",  out_ctrl,   0);
    chk("rst_occupancy", occupancy,  0);
    chk("rst_stall_cnt", stall_cnt,  0);
    rst = 1'b0;

    // streaming with out_ready held high
    step(0, 1, 1, 0, 0, 1, 0, 0);
    repeat (5) step(0, 1, 1, 0, 0, 1, 1, 1);
    step(0, 0, 1, 0, 0, 1, 1, 1);
    step(0, 0, 1, 0, 0, 1, 0, 0);

    // backpressure: A head, B skid, C held
    step(0, 1, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 1, 1, 1);
    step(0, 1, 0, 0, 0, 0, 1, 2);
    step(0, 1, 1, 0, 0, 0, 1, 2);
    step(0, 1, 1, 0, 0, 1, 1, 1);
    step(0, 0, 1, 0, 0, 1, 1, 1);
    step(0, 0, 1, 0, 0, 1, 0, 0);

    // flush with full skid, then flush dropping an accepted beat
    step(0, 1, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 1, 1, 1);
    step(0, 1, 0, 1, 0, 0, 1, 2);
    step(0, 1, 1, 1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0, 1, 0, 0);

    // stall counter saturation and clear-with-stall
    step(0, 1, 0, 0, 0, 1, 0, 0);
    repeat (20) step(0, 0, 0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1, 1);
    step(0, 0, 1, 0, 0, 1, 1, 1);
    step(0, 0, 1, 0, 0, 1, 0, 0);

    // reset while two entries are held
    step(0, 1, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1, 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid,  0);
    chk("mid_rst_out_ctrl",  out_ctrl,   0);
    chk("mid_rst_occupancy", occupancy,  0);
    chk("mid_rst_stall_cnt", stall_cnt,  0);
    chk("mid_rst_stall4",    stall_cnt4, 0);
    chk("mid_rst_in_ready",  in_ready,   0);
    q.delete(); exp_st = '0; exp_st4 = '0;
    @(posedge clk);
    #1;
    chk("held_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    step(0, 0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0, 1, 1, 1);
    step(0, 0, 1, 0, 0, 1, 0, 0);

    // single-entry variant, out_ready toggling under continuous in_valid
    step(1, 1, 1, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0, 1, 1);
    step(1, 1, 1, 0, 0, 1, 1, 1);
    step(1, 1, 0, 0, 0, 0, 1, 1);
    step(1, 1, 1, 0, 0, 1, 1, 1);
    step(1, 0, 1, 0, 0, 1, 1, 1);
    step(1, 0, 1, 0, 0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
